// File: rtl/clock_hms_if.sv
// Time/load bus between clock_hms and its user (display decode, setting logic).
// Alarm signals exist only when CLOCK_HMS_ALARM_EN is defined.
interface clock_hms_if;
    logic       run_i;
    logic       mode24_i;
    logic       load_i;
    logic [6:0] load_hrs_i;
    logic       load_pm_i;
    logic [6:0] load_mins_i;
    logic [6:0] load_secs_i;
    logic [6:0] hrs_o;
    logic [6:0] mins_o;
    logic [6:0] secs_o;
    logic       pm_o;
    logic       sec_tick_o;
    logic       load_err_o;
`ifdef CLOCK_HMS_ALARM_EN
    logic       alarm_set_i;
    logic [6:0] alarm_hrs_i;
    logic [6:0] alarm_mins_i;
    logic       alarm_o;
`endif

    modport slave (
        input  run_i, mode24_i, load_i, load_hrs_i, load_pm_i, load_mins_i, load_secs_i,
`ifdef CLOCK_HMS_ALARM_EN
        input  alarm_set_i, alarm_hrs_i, alarm_mins_i,
        output alarm_o,
`endif
        output hrs_o, mins_o, secs_o, pm_o, sec_tick_o, load_err_o
    );

    modport master (
        output run_i, mode24_i, load_i, load_hrs_i, load_pm_i, load_mins_i, load_secs_i,
`ifdef CLOCK_HMS_ALARM_EN
        output alarm_set_i, alarm_hrs_i, alarm_mins_i,
        input  alarm_o,
`endif
        input  hrs_o, mins_o, secs_o, pm_o, sec_tick_o, load_err_o
    );
endinterface

// File: rtl/clock_hms.sv
// Hours/minutes/seconds wall clock with 12/24-hour display, validated load and pause.
// Optional alarm comparator enabled by defining CLOCK_HMS_ALARM_EN.
module clock_hms #(
    parameter int CLK_DIV_P = 50000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    clock_hms_if.slave  bus
);

    localparam int PW = (CLK_DIV_P > 2) ? $clog2(CLK_DIV_P) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV_P - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    h24_q, h24_d;
    logic [5:0]    mins_q, mins_d;
    logic [5:0]    secs_q, secs_d;
    logic [6:0]    hrs_q, hrs_d;
    logic          pm_q, pm_d;
    logic          tick_q, tick_d;
    logic          err_q, err_d;

    logic          advance;
    logic          loadValid, loadOk, loadBad;
    logic [4:0]    loadH24;
    logic          secsWrap, minsWrap;
    logic [5:0]    secsAdv, minsAdv;
    logic [4:0]    h24Adv;
    logic          alarmBad;

    assign advance = bus.run_i && (presc_q == PRESC_MAX);

    // Load check and 12-hour to internal-hour conversion.
    always_comb begin
        loadValid = (bus.load_mins_i <= 7'd59) && (bus.load_secs_i <= 7'd59);
        loadH24   = bus.load_hrs_i[4:0];
        if (bus.mode24_i) begin
            loadValid = loadValid && (bus.load_hrs_i <= 7'd23);
        end else begin
            loadValid = loadValid && (bus.load_hrs_i >= 7'd1) && (bus.load_hrs_i <= 7'd12);
            if (bus.load_hrs_i[4:0] == 5'd12) begin
                loadH24 = bus.load_pm_i ? 5'd12 : 5'd0;
            end else if (bus.load_pm_i) begin
                loadH24 = bus.load_hrs_i[4:0] + 5'd12;
            end
        end
    end

    assign loadOk  = bus.load_i && loadValid;
    assign loadBad = bus.load_i && !loadValid;

    // Ripple carry seconds -> minutes -> hours, all resolved in one edge.
    always_comb begin
        secsWrap = (secs_q == 6'd59);
        minsWrap = (mins_q == 6'd59);
        secsAdv  = secsWrap ? 6'd0 : secs_q + 6'd1;
        minsAdv  = mins_q;
        h24Adv   = h24_q;
        if (secsWrap) begin
            minsAdv = minsWrap ? 6'd0 : mins_q + 6'd1;
            if (minsWrap) begin
                h24Adv = (h24_q == 5'd23) ? 5'd0 : h24_q + 5'd1;
            end
        end
    end

    always_comb begin
        presc_d = presc_q;
        h24_d   = h24_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        if (loadOk) begin
            presc_d = '0;
            h24_d   = loadH24;
            mins_d  = bus.load_mins_i[5:0];
            secs_d  = bus.load_secs_i[5:0];
        end else if (bus.run_i) begin
            presc_d = advance ? '0 : presc_q + PW'(1);
            if (advance) begin
                h24_d  = h24Adv;
                mins_d = minsAdv;
                secs_d = secsAdv;
            end
        end
    end

    // Display is derived from the next hour so it lines up with mins/secs.
    always_comb begin
        pm_d = (h24_d >= 5'd12);
        if (bus.mode24_i) begin
            hrs_d = {2'b00, h24_d};
        end else if (h24_d == 5'd0 || h24_d == 5'd12) begin
            hrs_d = 7'd12;
        end else if (h24_d > 5'd12) begin
            hrs_d = {2'b00, h24_d - 5'd12};
        end else begin
            hrs_d = {2'b00, h24_d};
        end
        tick_d = advance && !loadOk;
        err_d  = loadBad || alarmBad;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            h24_q   <= '0;
            mins_q  <= '0;
            secs_q  <= '0;
            hrs_q   <= bus.mode24_i ? 7'd0 : 7'd12;
            pm_q    <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            h24_q   <= h24_d;
            mins_q  <= mins_d;
            secs_q  <= secs_d;
            hrs_q   <= hrs_d;
            pm_q    <= pm_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

`ifdef CLOCK_HMS_ALARM_EN
    logic [4:0] alarmHrs_q, alarmHrs_d;
    logic [5:0] alarmMins_q, alarmMins_d;
    logic       alarm_q, alarm_d;
    logic       alarmValid;

    // Alarm fires only from a real advance landing on hh:mm:00, never from a load.
    always_comb begin
        alarmValid  = (bus.alarm_hrs_i <= 7'd23) && (bus.alarm_mins_i <= 7'd59);
        alarmBad    = bus.alarm_set_i && !alarmValid;
        alarmHrs_d  = alarmHrs_q;
        alarmMins_d = alarmMins_q;
        if (bus.alarm_set_i && alarmValid) begin
            alarmHrs_d  = bus.alarm_hrs_i[4:0];
            alarmMins_d = bus.alarm_mins_i[5:0];
        end
        alarm_d = advance && !loadOk && (h24Adv == alarmHrs_q)
                  && (minsAdv == alarmMins_q) && (secsAdv == 6'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alarmHrs_q  <= '0;
            alarmMins_q <= '0;
            alarm_q     <= 1'b0;
        end else begin
            alarmHrs_q  <= alarmHrs_d;
            alarmMins_q <= alarmMins_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bus.alarm_o = alarm_q;
`else
    assign alarmBad = 1'b0;
`endif

    assign bus.hrs_o      = hrs_q;
    assign bus.mins_o     = {1'b0, mins_q};
    assign bus.secs_o     = {1'b0, secs_q};
    assign bus.pm_o       = pm_q;
    assign bus.sec_tick_o = tick_q;
    assign bus.load_err_o = err_q;

endmodule

// File: tb/tb_clock_hms.sv
// Directed bench for clock_hms with CLK_DIV_P = 4; alarm scenario runs when CLOCK_HMS_ALARM_EN is defined.
module tb_clock_hms;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    clock_hms_if bus();

    clock_hms #(.CLK_DIV_P(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Packed view: hrs|mins|secs (7 bits each) then pm, tick, err.
    function automatic logic [23:0] obs();
        return {bus.hrs_o, bus.mins_o, bus.secs_o, bus.pm_o, bus.sec_tick_o, bus.load_err_o};
    endfunction

    function automatic logic [23:0] pk(input int h, input int m, input int s,
                                       input bit pm, input bit tick, input bit err);
        return {7'(h), 7'(m), 7'(s), pm, tick, err};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_load(input int h, input bit pm, input int m, input int s);
        bus.load_i      = 1'b1;
        bus.load_hrs_i  = 7'(h);
        bus.load_pm_i   = pm;
        bus.load_mins_i = 7'(m);
        bus.load_secs_i = 7'(s);
        step(1);
        bus.load_i      = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] want;
        rst = 1'b1;
        bus.mode24_i = 1'b0;
        bus.run_i = 1'b0;
        step(2);
        want = pk(12, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL reset: got %h want %h", obs(), want);
        end
        rst = 1'b0;
        bus.run_i = 1'b1;
    endtask

    task automatic test_count();
        logic [23:0] want;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            want = pk(12, 0, i / 4, 0, (i % 4) == 0, 0);
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("[TB] FAIL count[%0d]: got %h want %h", i, obs(), want);
            end
        end
    endtask

    task automatic test_rollover24();
        logic [23:0] want [4];
        int          gap  [4] = '{1, 3, 1, 4};
        want[0] = pk(23, 59, 58, 1, 0, 0);
        want[1] = pk(23, 59, 58, 1, 0, 0);
        want[2] = pk(23, 59, 59, 1, 1, 0);
        want[3] = pk(0, 0, 0, 0, 1, 0);
        bus.mode24_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) do_load(23, 1'b0, 59, 58);
            else        step(gap[i]);
            checks++;
            if (obs() !== want[i]) begin
                errors++;
                $display("[TB] FAIL rollover24[%0d]: got %h want %h", i, obs(), want[i]);
            end
        end
    endtask

    task automatic test_12h();
        logic [23:0] want;
        bus.mode24_i = 1'b0;
        do_load(11, 1'b0, 59, 59);
        want = pk(11, 59, 59, 0, 0, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL load12: got %h want %h", obs(), want);
        end
        step(4);
        want = pk(12, 0, 0, 1, 1, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL noon12: got %h want %h", obs(), want);
        end
        bus.mode24_i = 1'b1;
        step(1);
        want = pk(12, 0, 0, 1, 0, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL noon24: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_load_errors();
        logic [23:0] want;
        int          hv [3] = '{24, 0, 10};
        int          mv [3] = '{0, 10, 60};
        bit          md [3] = '{1'b1, 1'b0, 1'b1};
        bus.run_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mode24_i = md[i];
            do_load(hv[i], 1'b0, mv[i], 0);
            want = pk(12, 0, 0, 1, 0, 1);
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("[TB] FAIL load_err[%0d]: got %h want %h", i, obs(), want);
            end
            step(1);
            want = pk(12, 0, 0, 1, 0, 0);
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("[TB] FAIL err_clear[%0d]: got %h want %h", i, obs(), want);
            end
        end
    endtask

    task automatic test_load_on_advance();
        logic [23:0] want;
        bus.mode24_i = 1'b1;
        do_load(1, 1'b0, 2, 3);
        want = pk(1, 2, 3, 0, 0, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL load_paused: got %h want %h", obs(), want);
        end
        bus.run_i = 1'b1;
        step(3);
        do_load(5, 1'b0, 0, 0);
        want = pk(5, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL load_wins: got %h want %h", obs(), want);
        end
        step(3);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL early_tick: got %h want %h", obs(), want);
        end
        step(1);
        want = pk(5, 0, 1, 0, 1, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL tick_after_load: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_pause();
        logic [23:0] want;
        step(2);
        bus.run_i = 1'b0;
        want = pk(5, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("[TB] FAIL pause[%0d]: got %h want %h", i, obs(), want);
            end
        end
        bus.run_i = 1'b1;
        step(1);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL resume_hold: got %h want %h", obs(), want);
        end
        step(1);
        want = pk(5, 0, 2, 0, 1, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL resume_tick: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] want;
        step(2);
        bus.mode24_i = 1'b0;
        rst = 1'b1;
        do_load(9, 1'b0, 9, 9);
        rst = 1'b0;
        want = pk(12, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL reset_mid: got %h want %h", obs(), want);
        end
        step(3);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %h want %h", obs(), want);
        end
        step(1);
        want = pk(12, 0, 1, 0, 1, 0);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL reset_tick: got %h want %h", obs(), want);
        end
    endtask

`ifdef CLOCK_HMS_ALARM_EN
    task automatic test_alarm();
        logic [23:0] want;
        bus.run_i = 1'b0;
        bus.mode24_i = 1'b1;
        bus.alarm_set_i = 1'b1;
        bus.alarm_hrs_i = 7'd24;
        bus.alarm_mins_i = 7'd0;
        step(1);
        checks++;
        if (bus.load_err_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alarm_reject: got %b want 1", bus.load_err_o);
        end
        bus.alarm_hrs_i = 7'd7;
        bus.alarm_mins_i = 7'd30;
        step(1);
        bus.alarm_set_i = 1'b0;
        checks++;
        if (bus.load_err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alarm_accept: got %b want 0", bus.load_err_o);
        end
        do_load(7, 1'b0, 29, 59);
        bus.run_i = 1'b1;
        step(3);
        checks++;
        if (bus.alarm_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alarm_early: got %b want 0", bus.alarm_o);
        end
        step(1);
        want = pk(7, 30, 0, 0, 1, 0);
        checks++;
        if (obs() !== want || bus.alarm_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alarm_fire: got %h alarm %b want %h alarm 1", obs(), bus.alarm_o, want);
        end
    endtask
`endif

    initial begin
        bus.run_i       = 1'b0;
        bus.mode24_i    = 1'b0;
        bus.load_i      = 1'b0;
        bus.load_hrs_i  = '0;
        bus.load_pm_i   = 1'b0;
        bus.load_mins_i = '0;
        bus.load_secs_i = '0;
`ifdef CLOCK_HMS_ALARM_EN
        bus.alarm_set_i  = 1'b0;
        bus.alarm_hrs_i  = '0;
        bus.alarm_mins_i = '0;
`endif
        test_reset();
        test_count();
        test_rollover24();
        test_12h();
        test_load_errors();
        test_load_on_advance();
        test_pause();
        test_reset_mid();
`ifdef CLOCK_HMS_ALARM_EN
        test_alarm();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/clock_hms.md
# clock_hms

Parametrised successor to the team's first-generation wall clock. It derives a one-second tick from the system clock and keeps hours, minutes and seconds. Additions over the first generation:
- run-time selectable 12/24-hour display with an AM/PM flag;
- a validated load of all three fields, with error reporting;
- a pause control;
- a registered seconds-tick output.

It sits between the board clock and the display/BCD decode logic.

## Interface
- `CLK_DIV_P`, default 50000000, system clock cycles per second; must be ≥ 2.
- `clk_i`  in  1  system clock; all logic rises on its positive edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `run_i`  in  1  1 = time advances; 0 = prescaler and time hold.
- `mode24_i`  in  1  1 = 24-hour display, 0 = 12-hour display; may change at any time.
- `load_i`  in  1  single-cycle load strobe.
- `load_hrs_i`  in  7  hour to load, in the format selected by `mode24_i`.
- `load_pm_i`  in  1  PM flag for a 12-hour load; ignored in 24-hour mode.
- `load_mins_i`  in  7  minute to load.
- `load_secs_i`  in  7  second to load.
- `hrs_o`  out  7  displayed hour.
- `mins_o`  out  7  minute, 0–59.
- `secs_o`  out  7  second, 0–59.
- `pm_o`  out  1  1 when the internal hour is ≥ 12, in either mode.
- `sec_tick_o`  out  1  one-cycle pulse each time the time advances.
- `load_err_o`  out  1  one-cycle pulse when a load is rejected.

## Operation
- The internal hour `h24` runs 0–23 in both modes.
  - Display in 24-hour mode: `hrs_o = h24`.
  - Display in 12-hour mode: `hrs_o = 12` when `h24` is 0 or 12; otherwise `hrs_o = h24 mod 12`.
  - `hrs_o` and `pm_o` are registered and recomputed every cycle from `h24` and `mode24_i`.
- Prescaler counts 0 to `CLK_DIV_P-1`. It increments only while `run_i` = 1 and wraps to 0.
- The cycle the prescaler is at `CLK_DIV_P-1` with `run_i` = 1 is the advance cycle.
- Advance carries: seconds 59→0 carries into minutes; minutes 59→0 carries into `h24`; `h24` 23→0.
  - Carry is combinational within the same edge; all fields update on one edge.
- Load is accepted when all of the following hold:
  - `mins` ≤ 59 and `secs` ≤ 59;
  - 24-hour mode: hour ≤ 23;
  - 12-hour mode: hour is 1–12.
- A 12-hour load converts to `h24` as follows:
  - 12 AM → 0;
  - 12 PM → 12;
  - h AM → h;
  - h PM → h+12.
- An accepted load writes all three fields and clears the prescaler to 0.
- A rejected load changes nothing and raises `load_err_o` for one cycle.
- Load and advance in the same cycle: the load wins and that advance is dropped. A rejected load does not suppress the advance.
- `run_i` = 0 does not block loads.

## Timing
- Reset values: `h24`, minutes, seconds and prescaler = 0; `sec_tick_o` = 0; `load_err_o` = 0; `pm_o` = 0.
  - `hrs_o` reads 0 in 24-hour mode and 12 in 12-hour mode; valid from the first cycle after reset.
- `rst_i` asserted mid-count or coincident with `load_i` overrides everything on that edge.
- Advance latency:
  - The new time is visible on outputs one cycle after the advance-cycle edge.
  - `sec_tick_o` is high in exactly that same cycle.
- Load latency:
  - New time is visible on outputs one cycle after the `load_i` edge, with `sec_tick_o` = 0.
  - `load_err_o` is asserted in the cycle following a rejected strobe.
- After reset or an accepted load, the next advance occurs after exactly `CLK_DIV_P` cycles with `run_i` = 1.
- A change of `mode24_i` affects `hrs_o` one cycle later and never alters `h24`.

## Configuration
- `CLOCK_HMS_ALARM_EN`
  - Defined: adds inputs `alarm_set_i` (1), `alarm_hrs_i` (7, 24-hour format) and `alarm_mins_i` (7), and output `alarm_o` (1).
    - `alarm_set_i` latches the alarm; a value out of range is rejected and `load_err_o` pulses.
    - `alarm_o` pulses for one cycle, coincident with `sec_tick_o`, when an advance produces `h24`/min equal to the alarm with secs = 0.
    - A load never fires the alarm.
    - Alarm registers reset to 0:00.
  - Not defined: none of these ports or registers exist.

## Test plan
- `CLK_DIV_P` = 4: reset, then `run_i` = 1 for 12 cycles.
  - Required: `secs_o` 0→1→2→3, one `sec_tick_o` per 4 cycles; `hrs_o` = 12 when `mode24_i` = 0.
- 24-hour mode: load 23:59:58.
  - Required: after two advances, outputs are 0:00:00 with `pm_o` = 0, and each advance raises a tick.
- 12-hour mode: load 11:59:59 AM.
  - Required: one advance gives `hrs_o` = 12, `pm_o` = 1.
  - Then toggle `mode24_i` = 1 → `hrs_o` = 12 the next cycle.
- Loads of 24:00:00 (24-hour mode), 0:10:00 (12-hour mode) and 10:60:00.
  - Required: each gives a `load_err_o` pulse and no change to time.
- `load_i` on the advance cycle loading 5:00:00.
  - Required: outputs show 5:00:00 and no tick; the next tick comes 4 cycles later.
- `run_i` = 0 for 10 cycles mid-count.
  - Required: no ticks; the prescaler resumes from its held value.
- `rst_i` mid-count.
  - Required: all outputs reach their reset values one cycle later.
- With `CLOCK_HMS_ALARM_EN`: alarm 7:30, load 7:29:59.
  - Required: the next advance raises `alarm_o` and `sec_tick_o` together.
